// File: rtl/piano_pkg.sv
// Shared constants for the piano voice scheduler: note table and field widths.
// Optional voice stealing is built when PIANO_VOICE_STEAL_EN is defined.
package piano_pkg;

    localparam int KEY_IDX_W     = 4;
    localparam int HALF_PERIOD_W = 19;
    localparam int NUM_NOTES     = 10;

    // Square-wave half periods in CLOCK_50 cycles, C4 up to E5.
    localparam logic [HALF_PERIOD_W-1:0] HALF_PERIOD [NUM_NOTES] = '{
        19'd95554, 19'd85132, 19'd75842, 19'd71586, 19'd63775,
        19'd56818, 19'd50620, 19'd47778, 19'd42568, 19'd37922
    };

    function automatic logic [HALF_PERIOD_W-1:0] half_period_of(
        input logic [KEY_IDX_W-1:0] key
    );
        if (int'(key) < NUM_NOTES)
            return HALF_PERIOD[int'(key)];
        return '0;
    endfunction

endpackage

// File: rtl/piano_audio_if.sv
// Sample handshake towards the audio codec controller output FIFO.
// The scheduler is the master; the codec controller is the slave.
interface piano_audio_if;

    logic               audio_out_allowed;
    logic               write_audio_out;
    logic signed [31:0] left_channel_audio_out;
    logic signed [31:0] right_channel_audio_out;

    modport master (
        input  audio_out_allowed,
        output write_audio_out,
        output left_channel_audio_out,
        output right_channel_audio_out
    );

    modport slave (
        output audio_out_allowed,
        input  write_audio_out,
        input  left_channel_audio_out,
        input  right_channel_audio_out
    );

endinterface

// File: rtl/piano_voice_scheduler_tone_voice.sv
// One square-wave tone voice: half-period counter plus phase flip-flop.
// A load restarts the voice high; a disabled voice rests at count 0, phase 0.
module tone_voice
    import piano_pkg::*;
(
    input  logic                     CLOCK_50,
    input  logic                     reset,
    input  logic                     load,
    input  logic                     enable,
    input  logic [HALF_PERIOD_W-1:0] half_period,
    output logic                     phase
);

    logic [HALF_PERIOD_W-1:0] hp_q;
    logic [HALF_PERIOD_W-1:0] cnt_q;

    // Count 0..half period, then wrap and flip the square phase.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            hp_q  <= '0;
            cnt_q <= '0;
            phase <= 1'b0;
        end else if (load) begin
            hp_q  <= half_period;
            cnt_q <= '0;
            phase <= 1'b1;
        end else if (!enable) begin
            cnt_q <= '0;
            phase <= 1'b0;
        end else if (cnt_q == hp_q) begin
            cnt_q <= '0;
            phase <= ~phase;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/piano_voice_scheduler.sv
// Polyphonic key scan, voice allocation, mixer and fixed-rate sample output.
// Define PIANO_VOICE_STEAL_EN to let a new key steal a voice when all are busy.
module piano_voice_scheduler
    import piano_pkg::*;
#(
    parameter int NUM_KEYS   = 10,
    parameter int NUM_VOICES = 4,
    parameter int AMPLITUDE  = 10000000,
    parameter int SAMPLE_DIV = 1042
) (
    input  logic                    CLOCK_50,
    input  logic                    reset,
    input  logic [NUM_KEYS-1:0]     key_down,
    piano_audio_if.master           audio,
    output logic [NUM_VOICES-1:0]   voice_busy,
    output logic [4*NUM_VOICES-1:0] voice_key,
    output logic                    overrun
);

    localparam int DIV_W  = $clog2(SAMPLE_DIV);
    localparam int VIDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic signed [31:0] AMP = 32'(AMPLITUDE);

    if (64'(NUM_VOICES) * 64'(AMPLITUDE) >= 64'd2147483648) begin : g_amp_chk
        $error("NUM_VOICES*AMPLITUDE overflows the 32-bit mix");
    end
    if (NUM_KEYS > NUM_NOTES) begin : g_key_chk
        $error("NUM_KEYS exceeds the note table");
    end

    logic [KEY_IDX_W-1:0]     scan_ptr;
    logic [HALF_PERIOD_W-1:0] scan_hp;
    logic                     key_now;
    logic                     held;
    logic                     have_free;
    logic [VIDX_W-1:0]        hit_idx;
    logic [VIDX_W-1:0]        free_idx;
    logic [NUM_VOICES-1:0]    load;
    logic [NUM_VOICES-1:0]    phase;
    logic signed [31:0]       mix;
    logic [DIV_W-1:0]         div_cnt;
    logic                     tick;
    logic                     fire;
    logic                     pending;
    logic signed [31:0]       sample_q;

    assign key_now = key_down[scan_ptr];
    assign scan_hp = half_period_of(scan_ptr);

    // Visit one key per cycle, wrapping after the last key.
    always_ff @(posedge CLOCK_50) begin
        if (reset)
            scan_ptr <= '0;
        else if (scan_ptr == KEY_IDX_W'(NUM_KEYS - 1))
            scan_ptr <= '0;
        else
            scan_ptr <= scan_ptr + 1'b1;
    end

    // Find the voice holding the scanned key and the lowest free voice.
    always_comb begin
        held      = 1'b0;
        have_free = 1'b0;
        hit_idx   = '0;
        free_idx  = '0;
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (voice_busy[v] &&
                voice_key[4*v +: KEY_IDX_W] == scan_ptr) begin
                held    = 1'b1;
                hit_idx = VIDX_W'(v);
            end
            if (!voice_busy[v]) begin
                have_free = 1'b1;
                free_idx  = VIDX_W'(v);
            end
        end
    end

`ifdef PIANO_VOICE_STEAL_EN
    logic [VIDX_W-1:0] steal_ptr;

    // Round-robin victim pointer, advanced on every steal.
    always_ff @(posedge CLOCK_50) begin
        if (reset)
            steal_ptr <= '0;
        else if (key_now && !held && !have_free)
            steal_ptr <= (steal_ptr == VIDX_W'(NUM_VOICES - 1)) ?
                         '0 : steal_ptr + 1'b1;
    end
`endif

    // Pick the voice to (re)load for a newly seen pressed key.
    always_comb begin
        load = '0;
        if (key_now && !held) begin
            if (have_free)
                load[free_idx] = 1'b1;
`ifdef PIANO_VOICE_STEAL_EN
            else
                load[steal_ptr] = 1'b1;
`endif
        end
    end

    // Voice ownership: claim on load, release when the held key lifts.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            voice_busy <= '0;
            voice_key  <= '0;
        end else begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (load[v]) begin
                    voice_busy[v]               <= 1'b1;
                    voice_key[4*v +: KEY_IDX_W] <= scan_ptr;
                end
            end
            if (!key_now && held)
                voice_busy[hit_idx] <= 1'b0;
        end
    end

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
        tone_voice u_voice (
            .CLOCK_50    (CLOCK_50),
            .reset       (reset),
            .load        (load[v]),
            .enable      (voice_busy[v]),
            .half_period (scan_hp),
            .phase       (phase[v])
        );
    end

    // Sum +/-AMPLITUDE over busy voices; idle voices add nothing.
    always_comb begin
        mix = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (voice_busy[v])
                mix = mix + (phase[v] ? AMP : -AMP);
        end
    end

    assign tick = (div_cnt == DIV_W'(SAMPLE_DIV - 1));
    assign fire = pending && audio.audio_out_allowed;

    // Sample-rate divider, sample latch, pending flag and sticky overrun.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            div_cnt  <= '0;
            pending  <= 1'b0;
            sample_q <= '0;
            overrun  <= 1'b0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick) begin
                sample_q <= mix;
                pending  <= 1'b1;
                if (pending && !fire)
                    overrun <= 1'b1;
            end else if (fire) begin
                pending <= 1'b0;
            end
        end
    end

    assign audio.write_audio_out         = fire;
    assign audio.left_channel_audio_out  = sample_q;
    assign audio.right_channel_audio_out = sample_q;

endmodule

// File: tb/tb_piano_voice_scheduler.sv
// Directed bench for piano_voice_scheduler with a sample scoreboard.
// Expected samples are queued at each modelled tick and popped on writes.
module tb_piano_voice_scheduler;

    localparam int NK   = 10;
    localparam int NV   = 4;
    localparam int AMP  = 10000000;
    localparam int SDIV = 1042;

    logic            CLOCK_50 = 1'b0;
    logic            reset    = 1'b1;
    logic [NK-1:0]   key_down = '0;
    logic [NV-1:0]   voice_busy;
    logic [4*NV-1:0] voice_key;
    logic            overrun;

    piano_audio_if audio ();

    piano_voice_scheduler #(
        .NUM_KEYS   (NK),
        .NUM_VOICES (NV),
        .AMPLITUDE  (AMP),
        .SAMPLE_DIV (SDIV)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .key_down   (key_down),
        .audio      (audio),
        .voice_busy (voice_busy),
        .voice_key  (voice_key),
        .overrun    (overrun)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag,
                       input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic signed [31:0] v;
        bit                 c;
    } exp_t;

    exp_t               sb_q[$];
    int unsigned        cyc = 0;
    bit                 mpend = 1'b0;
    logic signed [31:0] exp_mix = '0;
    bit                 exp_chk = 1'b1;

    function automatic logic [NK-1:0] held_mask(input logic [NV-1:0] b,
                                                input logic [4*NV-1:0] k);
        logic [NK-1:0] m;
        int            idx;
        m = '0;
        for (int v = 0; v < NV; v++) begin
            idx = int'(k[4*v +: 4]);
            if (b[v] && idx < NK)
                m[idx] = 1'b1;
        end
        return m;
    endfunction

    // Reference model of the tick / pending / overwrite behaviour.
    always @(posedge CLOCK_50) begin
        bit tk;
        bit fr;
        if (reset) begin
            cyc   = 0;
            mpend = 1'b0;
            sb_q.delete();
        end else begin
            tk = ((cyc % SDIV) == SDIV - 1);
            fr = mpend && audio.audio_out_allowed;
            cyc++;
            if (tk) begin
                if (mpend && !fr && sb_q.size() > 0)
                    void'(sb_q.pop_back());
                sb_q.push_back('{exp_mix, exp_chk});
                mpend = 1'b1;
            end else if (fr) begin
                mpend = 1'b0;
            end
        end
    end

    // Compare every write (expected or not) against the scoreboard.
    always @(negedge CLOCK_50) begin
        bit   fr;
        exp_t e;
        if (!reset) begin
            fr = mpend && audio.audio_out_allowed;
            if (fr || audio.write_audio_out) begin
                chk("write_strobe", audio.write_audio_out, fr);
                if (fr && sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    if (e.c) begin
                        chk("sample_left", audio.left_channel_audio_out, e.v);
                        chk("sample_right", audio.right_channel_audio_out, e.v);
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    initial begin
        #(10 * 200000);
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit          found;
        int unsigned t0;

        audio.audio_out_allowed = 1'b1;
        step(3);
        @(negedge CLOCK_50);
        chk("rst_write", audio.write_audio_out, 0);
        chk("rst_left", audio.left_channel_audio_out, 0);
        chk("rst_right", audio.right_channel_audio_out, 0);
        chk("rst_busy", voice_busy, 0);
        chk("rst_key", voice_key, 0);
        chk("rst_overrun", overrun, 0);
        step(1);
        reset = 1'b0;

        // Single key: A4 allocates voice 0, then half period check.
        key_down = NK'(1) << 5;
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            @(negedge CLOCK_50);
            if (voice_busy != '0) found = 1'b1;
        end
        chk("single_alloc_found", found, 1);
        chk("single_busy", voice_busy, 4'b0001);
        chk("single_key", voice_key[3:0], 5);
        exp_mix = AMP;
        t0 = cyc;
        found = 1'b0;
        for (int i = 0; i < 60000 && !found; i++) begin
            @(negedge CLOCK_50);
            if (dut.g_voice[0].u_voice.phase == 1'b0) found = 1'b1;
        end
        chk("phase_toggle_found", found, 1);
        chk("half_period_cycles", cyc - t0, 56819);
        exp_mix = -AMP;
        step(1100);
        exp_chk = 1'b0;
        key_down = '0;
        step(12);
        chk("release_busy", voice_busy, 0);
        exp_mix = 0;
        exp_chk = 1'b1;

        // Mixer: three keys together.
        exp_chk = 1'b0;
        key_down = NK'(10'b00_0001_0101);
        step(12);
        @(negedge CLOCK_50);
        chk("mix_busy", voice_busy, 4'b0111);
        chk("mix_keys", held_mask(voice_busy, voice_key), 10'h015);
        exp_mix = 3 * AMP;
        exp_chk = 1'b1;
        step(2200);

        // Tick and write land on the same cycle.
        audio.audio_out_allowed = 1'b0;
        while ((cyc % SDIV) != 0) step(1);
        while ((cyc % SDIV) != SDIV - 1) step(1);
        audio.audio_out_allowed = 1'b1;
        step(1);
        audio.audio_out_allowed = 1'b0;
        step(5);
        @(negedge CLOCK_50);
        chk("coinc_overrun", overrun, 0);
        chk("coinc_no_write", audio.write_audio_out, 0);
        step(1);
        audio.audio_out_allowed = 1'b1;
        step(2);

        // Voice exhaustion: five keys for four voices.
        exp_chk = 1'b0;
        key_down = '0;
        step(12);
        while ((cyc % NK) != 5) step(1);
        key_down = NK'(10'h01F);
`ifdef PIANO_VOICE_STEAL_EN
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            @(negedge CLOCK_50);
            if (voice_key[3:0] == 4'd4 && voice_busy == 4'b1111) found = 1'b1;
        end
        chk("steal_found", found, 1);
        chk("steal_key0", voice_key[3:0], 4);
`else
        step(20);
        @(negedge CLOCK_50);
        chk("exh_busy", voice_busy, 4'b1111);
        chk("exh_keys", voice_key, 16'h3210);
        chk("exh_dropped", held_mask(voice_busy, voice_key), 10'h00F);
        step(1);
        key_down = NK'(10'h01D);
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            @(negedge CLOCK_50);
            if (voice_key[7:4] == 4'd4 && voice_busy[1]) found = 1'b1;
        end
        chk("exh_realloc_found", found, 1);
        chk("exh_realloc_keys", voice_key, 16'h3240);
        chk("exh_realloc_busy", voice_busy, 4'b1111);
        exp_mix = 4 * AMP;
        exp_chk = 1'b1;
        step(1100);
`endif

        // Held-off handshake.
        audio.audio_out_allowed = 1'b0;
        step(2 * SDIV);
        @(negedge CLOCK_50);
        chk("held_overrun", overrun, 1);
        chk("held_no_write", audio.write_audio_out, 0);
        step(1);
        audio.audio_out_allowed = 1'b1;
        step(5);

        // Reset mid-operation with three voices busy.
        exp_chk = 1'b0;
        key_down = NK'(10'h015);
        step(12);
`ifndef PIANO_VOICE_STEAL_EN
        @(negedge CLOCK_50);
        chk("pre_reset_busy", voice_busy, 4'b0111);
        step(1);
`endif
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        @(negedge CLOCK_50);
        chk("mid_rst_write", audio.write_audio_out, 0);
        chk("mid_rst_left", audio.left_channel_audio_out, 0);
        chk("mid_rst_right", audio.right_channel_audio_out, 0);
        chk("mid_rst_busy", voice_busy, 0);
        chk("mid_rst_key", voice_key, 0);
        chk("mid_rst_overrun", overrun, 0);
        step(6);
        @(negedge CLOCK_50);
        chk("realloc_busy", voice_busy, 4'b0111);
        chk("realloc_keys", voice_key, 16'h0420);
        exp_mix = 3 * AMP;
        exp_chk = 1'b1;
        step(1100);

        @(negedge CLOCK_50);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
